bcd_countdown_timer: RTL and testbench

// Loadable multi-digit BCD down-counter. It counts from a loaded decimal value to zero,
// one step per enabled clock, and flags expiry. It is the counting-down counterpart of
// mod10_counter: each digit wraps 0 -> 9 with a borrow into the next digit.
// It feeds the same 4-bit-per-digit display path that mod10_counter drives.

---
 rtl/bcd_timer_pkg.sv | 17 +
 rtl/bcd_down_digit.sv | 29 ++
 rtl/bcd_countdown_timer.sv | 87 ++++++++
 tb/tb_bcd_countdown_timer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// Digit values above 9 are clamped to 9 so the display path never sees a non-decimal nibble.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } timer_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter: loads a clamped value, or steps down on borrow_in.
// The digit wraps 0 -> 9 and passes the borrow on to the next digit.
module bcd_down_digit
    import bcd_timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       borrow_in,
    output logic [3:0] digit,
    output logic       is_zero,
    output logic       borrow_out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= bcd_clamp(load_digit);
        end else if (borrow_in) begin
            digit <= is_zero ? BCD_MAX : digit - 4'd1;
        end
    end

    assign is_zero    = (digit == 4'd0);
    assign borrow_out = borrow_in & is_zero;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Loadable multi-digit BCD down-counter with expiry flag and one-cycle done pulse.
//   state   | meaning
//   IDLE    | no countdown loaded (reset or zero load); count holds
//   RUN     | counting down one step per enabled clock
//   EXPIRED | reached zero; holds 0 until load or reset
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  expired,
    output logic                  done
);

    timer_state_t       state_q, state_d;
    logic               done_q, done_d;
    logic [DIGITS:0]    borrow;
    logic [DIGITS-1:0]  is_zero;
    logic               load_nonzero;
    logic               upper_zero;
    logic               terminal;

    assign borrow[0] = (state_q == RUN) & enable & ~load;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_down_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .load       (load),
            .load_digit (load_value[4*i +: 4]),
            .borrow_in  (borrow[i]),
            .digit      (count[4*i +: 4]),
            .is_zero    (is_zero[i]),
            .borrow_out (borrow[i+1])
        );
    end

    always_comb begin
        load_nonzero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            load_nonzero = load_nonzero | (bcd_clamp(load_value[4*i +: 4]) != 4'd0);
        end
        upper_zero = 1'b1;
        for (int i = 1; i < DIGITS; i++) begin
            upper_zero = upper_zero & is_zero[i];
        end
        terminal = upper_zero & (count[3:0] == 4'd1);
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = load_nonzero ? RUN : IDLE;
        end else if (state_q == RUN && enable) begin
            if (terminal) begin
                state_d = EXPIRED;
                done_d  = 1'b1;
            end else if (borrow[DIGITS]) begin
                // Stepping below zero is unreachable; park in EXPIRED rather than keep wrapping.
                state_d = EXPIRED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign running = (state_q == RUN);
    assign expired = (state_q == EXPIRED);
    assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed self-checking bench for bcd_countdown_timer (DIGITS = 2).
module tb_bcd_countdown_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       load;
    logic [7:0] load_value;
    logic [7:0] count;
    logic       running;
    logic       expired;
    logic       done;

    int total = 0;
    int bad   = 0;

    bcd_countdown_timer #(.DIGITS(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .running    (running),
        .expired    (expired),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] c, input logic r,
                           input logic e, input logic d);
        chk({tag, ".count"},   count,         c);
        chk({tag, ".running"}, {7'd0, running}, {7'd0, r});
        chk({tag, ".expired"}, {7'd0, expired}, {7'd0, e});
        chk({tag, ".done"},    {7'd0, done},    {7'd0, d});
    endtask

    logic [7:0] seq12 [12];
    logic       en5   [11];
    logic [7:0] exp5  [11];

    initial begin
        seq12 = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                  8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        en5   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp5  = '{8'h05, 8'h05, 8'h05, 8'h04, 8'h03, 8'h03, 8'h03, 8'h03,
                  8'h02, 8'h01, 8'h00};

        // Reset dominates a concurrent load
        reset = 1'b1; load = 1'b1; enable = 1'b0; load_value = 8'h42;
        step(); step();
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);

        // Load 12 and count down through the 10 -> 09 borrow to expiry
        reset = 1'b0; load = 1'b1; load_value = 8'h12;
        step();
        chk_all("load12", 8'h12, 1'b1, 1'b0, 1'b0);
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("cd12.count", count, seq12[i]);
            chk("cd12.done", {7'd0, done}, (i == 11) ? 8'd1 : 8'd0);
        end
        chk_all("cd12.end", 8'h00, 1'b0, 1'b1, 1'b1);

        // Enabled after expiry: stays at zero, no second done
        for (int i = 0; i < 20; i++) begin
            step();
            chk("post_exp.count", count, 8'h00);
            chk("post_exp.done", {7'd0, done}, 8'd0);
        end
        chk_all("post_exp.end", 8'h00, 1'b0, 1'b1, 1'b0);

        // Load 05 with a gapped enable pattern
        enable = 1'b0; load = 1'b1; load_value = 8'h05;
        step();
        chk_all("load05", 8'h05, 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        for (int i = 0; i < 11; i++) begin
            enable = en5[i];
            step();
            chk("gap.count", count, exp5[i]);
            chk("gap.done", {7'd0, done}, (i == 10) ? 8'd1 : 8'd0);
        end
        enable = 1'b0;
        step();
        chk_all("gap.end", 8'h00, 1'b0, 1'b1, 1'b0);

        // Clamp of an illegal tens digit, then a zero load returns to IDLE
        load = 1'b1; load_value = 8'hA7;
        step();
        chk_all("clampA7", 8'h97, 1'b1, 1'b0, 1'b0);
        load_value = 8'h0C;
        step();
        chk_all("clamp0C", 8'h09, 1'b1, 1'b0, 1'b0);
        load_value = 8'h00;
        step();
        chk_all("zero_load", 8'h00, 1'b0, 1'b0, 1'b0);
        load = 1'b0; enable = 1'b1;
        step();
        chk_all("idle_hold", 8'h00, 1'b0, 1'b0, 1'b0);

        // Load/enable collision: load wins, then normal decrement
        load = 1'b1; enable = 1'b0; load_value = 8'h30;
        step();
        load = 1'b0; enable = 1'b1;
        step();
        chk_all("dec30", 8'h29, 1'b1, 1'b0, 1'b0);
        load = 1'b1; load_value = 8'h25;
        step();
        chk_all("collide", 8'h25, 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        step();
        chk_all("after_collide", 8'h24, 1'b1, 1'b0, 1'b0);
        enable = 1'b0;
        step();
        chk_all("hold24", 8'h24, 1'b1, 1'b0, 1'b0);

        // Abort with reset mid-count
        enable = 1'b1; reset = 1'b1;
        step();
        chk_all("abort", 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        chk_all("abort_idle", 8'h00, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
